// File: rtl/banked_data_mem.sv
// banked_data_mem
//   Multi-bank 32-bit data memory. The CPU port does word reads and byte-enabled writes. The VGA
//   port does byte reads. Each bank is an inferred dual-port RAM. Both ports answer one cycle
//   after the request (rvalid). CPU accesses that are misaligned or out of range come back with
//   an error.
//
//   Optional feature: define KEY_BANK_EN to make bank NUM_BANKS-1 a keyboard bank. The CPU cannot
//   write it (such a write is reported as an error), and the key_* port writes whole words to it.
//
// Ports
//   clk, rst_n                 clock; async active-low reset
//   i_cpu_req/wren/addr/be/wdata   CPU access request
//   o_cpu_rvalid/rdata/err         CPU response, one cycle after i_cpu_req
//   i_vga_req/addr                 VGA byte read request
//   o_vga_rvalid/rdata             VGA response, one cycle after i_vga_req
//   i_key_we/addr/wdata            keyboard word write into the key bank (KEY_BANK_EN only)

module banked_data_mem #(
    parameter int unsigned NUM_BANKS  = 3,
    parameter int unsigned BANK_WORDS = 1024,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_cpu_req,
    input  logic                          i_cpu_wren,
    input  logic [ADDR_W-1:0]             i_cpu_addr,
    input  logic [3:0]                    i_cpu_be,
    input  logic [31:0]                   i_cpu_wdata,
    output logic                          o_cpu_rvalid,
    output logic [31:0]                   o_cpu_rdata,
    output logic                          o_cpu_err,
    input  logic                          i_vga_req,
    input  logic [ADDR_W-1:0]             i_vga_addr,
    output logic                          o_vga_rvalid,
    output logic [7:0]                    o_vga_rdata
`ifdef KEY_BANK_EN
    ,
    input  logic                          i_key_we,
    input  logic [$clog2(BANK_WORDS)-1:0] i_key_addr,
    input  logic [31:0]                   i_key_wdata
`endif
);

    localparam int unsigned OFF_W  = $clog2(BANK_WORDS);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [ADDR_W-1:0] TOTAL_WORDS = ADDR_W'(NUM_BANKS * BANK_WORDS);

    typedef enum logic {StIdle, StResp} pipe_state_e;

    // ---------------- address decode ----------------
    logic [ADDR_W-1:0] w_cpu_word, w_vga_word;
    logic [BANK_W-1:0] w_cpu_bank, w_vga_bank;
    logic [OFF_W-1:0]  w_cpu_off, w_vga_off;
    logic              w_cpu_legal, w_vga_legal, w_cpu_key_wr, w_cpu_err;
    logic              w_cpu_we, w_cpu_rd, w_vga_rd;

    assign w_cpu_word  = {2'b00, i_cpu_addr[ADDR_W-1:2]};
    assign w_vga_word  = {2'b00, i_vga_addr[ADDR_W-1:2]};
    assign w_cpu_legal = w_cpu_word < TOTAL_WORDS;
    assign w_vga_legal = w_vga_word < TOTAL_WORDS;
    assign w_cpu_bank  = w_cpu_word[OFF_W +: BANK_W];
    assign w_vga_bank  = w_vga_word[OFF_W +: BANK_W];
    assign w_cpu_off   = w_cpu_word[OFF_W-1:0];
    assign w_vga_off   = w_vga_word[OFF_W-1:0];

`ifdef KEY_BANK_EN
    assign w_cpu_key_wr = i_cpu_wren && (w_cpu_bank == BANK_W'(NUM_BANKS - 1));
`else
    assign w_cpu_key_wr = 1'b0;
`endif

    assign w_cpu_err = (i_cpu_addr[1:0] != 2'b00) || !w_cpu_legal || w_cpu_key_wr;
    // The RAM has no reset, so writes have to be blocked while reset is held.
    assign w_cpu_we  = rst_n && i_cpu_req && i_cpu_wren && !w_cpu_err;
    assign w_cpu_rd  = i_cpu_req && !i_cpu_wren && !w_cpu_err;
    assign w_vga_rd  = i_vga_req && w_vga_legal;

    // ---------------- RAM banks ----------------
    logic [31:0] w_cpu_bank_q [NUM_BANKS];
    logic [31:0] w_vga_bank_q [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0] r_mem [BANK_WORDS];
        logic [31:0] r_cpu_q, r_vga_q;
        logic        w_cpu_hit, w_vga_hit;

        assign w_cpu_hit = (w_cpu_bank == BANK_W'(b));
        assign w_vga_hit = (w_vga_bank == BANK_W'(b));

        // Read-before-write: a read in the same cycle as a write to the same word gets the old data.
        always_ff @(posedge clk) begin
            if (w_cpu_we && w_cpu_hit) begin
                for (int l = 0; l < 4; l++) begin
                    if (i_cpu_be[l]) r_mem[w_cpu_off][8*l +: 8] <= i_cpu_wdata[8*l +: 8];
                end
            end
`ifdef KEY_BANK_EN
            if ((b == NUM_BANKS - 1) && rst_n && i_key_we) r_mem[i_key_addr] <= i_key_wdata;
`endif
            if (w_cpu_rd && w_cpu_hit) r_cpu_q <= r_mem[w_cpu_off];
            if (w_vga_rd && w_vga_hit) r_vga_q <= r_mem[w_vga_off];
        end

        assign w_cpu_bank_q[b] = r_cpu_q;
        assign w_vga_bank_q[b] = r_vga_q;
    end

    // ---------------- CPU response pipeline ----------------
    pipe_state_e       r_cpu_state, w_cpu_state_d;
    logic              r_cpu_err, r_cpu_rd;
    logic [BANK_W-1:0] r_cpu_sel;
    logic [31:0]       r_cpu_hold, w_cpu_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_state <= StIdle;
            r_cpu_err   <= 1'b0;
            r_cpu_rd    <= 1'b0;
            r_cpu_sel   <= '0;
            r_cpu_hold  <= '0;
        end else begin
            r_cpu_state <= w_cpu_state_d;
            r_cpu_err   <= i_cpu_req && w_cpu_err;
            r_cpu_rd    <= w_cpu_rd;
            r_cpu_sel   <= w_cpu_rd ? w_cpu_bank : '0;
            // Remember the last response so rdata holds across idle cycles.
            if (o_cpu_rvalid) r_cpu_hold <= w_cpu_rdata;
        end
    end

    always_comb begin
        w_cpu_state_d = i_cpu_req ? StResp : StIdle;
    end

    always_comb begin
        o_cpu_rvalid = (r_cpu_state == StResp);
        o_cpu_err    = o_cpu_rvalid && r_cpu_err;
        w_cpu_rdata  = r_cpu_hold;
        if (o_cpu_rvalid) w_cpu_rdata = r_cpu_rd ? w_cpu_bank_q[r_cpu_sel] : 32'h0;
        o_cpu_rdata  = w_cpu_rdata;
    end

    // ---------------- VGA response pipeline ----------------
    pipe_state_e       r_vga_state, w_vga_state_d;
    logic              r_vga_ok;
    logic [BANK_W-1:0] r_vga_sel;
    logic [1:0]        r_vga_lane;
    logic [7:0]        r_vga_hold, w_vga_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_state <= StIdle;
            r_vga_ok    <= 1'b0;
            r_vga_sel   <= '0;
            r_vga_lane  <= '0;
            r_vga_hold  <= '0;
        end else begin
            r_vga_state <= w_vga_state_d;
            r_vga_ok    <= w_vga_rd;
            r_vga_sel   <= w_vga_rd ? w_vga_bank : '0;
            r_vga_lane  <= w_vga_rd ? i_vga_addr[1:0] : 2'b00;
            if (o_vga_rvalid) r_vga_hold <= w_vga_rdata;
        end
    end

    always_comb begin
        w_vga_state_d = i_vga_req ? StResp : StIdle;
    end

    always_comb begin
        o_vga_rvalid = (r_vga_state == StResp);
        w_vga_rdata  = r_vga_hold;
        if (o_vga_rvalid) w_vga_rdata = r_vga_ok ? w_vga_bank_q[r_vga_sel][8*r_vga_lane +: 8] : 8'h0;
        o_vga_rdata  = w_vga_rdata;
    end

endmodule

// File: tb/tb_banked_data_mem.sv
module tb_banked_data_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_wren = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic        cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;
    logic        vga_req = 1'b0;
    logic [31:0] vga_addr = '0;
    logic        vga_rvalid;
    logic [7:0]  vga_rdata;
    logic        key_we = 1'b0;
    logic [9:0]  key_addr = '0;
    logic [31:0] key_wdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    banked_data_mem dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cpu_req    (cpu_req),
        .i_cpu_wren   (cpu_wren),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_be     (cpu_be),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_err    (cpu_err),
        .i_vga_req    (vga_req),
        .i_vga_addr   (vga_addr),
        .o_vga_rvalid (vga_rvalid),
        .o_vga_rdata  (vga_rdata)
`ifdef KEY_BANK_EN
        ,
        .i_key_we     (key_we),
        .i_key_addr   (key_addr),
        .i_key_wdata  (key_wdata)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One CPU access; returns at the negedge where its response is visible.
    task automatic cpu_acc(input logic wren, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wren = wren; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0; cpu_wren = 1'b0;
    endtask

    task automatic cpu_read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        cpu_acc(1'b0, addr, 4'h0, 32'h0);
        check_val({tag, "_rvalid"}, {31'b0, cpu_rvalid}, 32'd1);
        check_val({tag, "_err"}, {31'b0, cpu_err}, 32'd0);
        check_val({tag, "_rdata"}, cpu_rdata, exp);
    endtask

    task automatic vga_read_chk(input string tag, input logic [31:0] addr, input logic [7:0] exp);
        @(negedge clk);
        vga_req = 1'b1; vga_addr = addr;
        @(negedge clk);
        vga_req = 1'b0;
        check_val({tag, "_rvalid"}, {31'b0, vga_rvalid}, 32'd1);
        check_val({tag, "_rdata"}, {24'b0, vga_rdata}, {24'b0, exp});
    endtask

    logic [7:0] lane_exp [4];

    initial begin
        lane_exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        // Reset state
        #12;
        check_val("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        check_val("rst_cpu_err", {31'b0, cpu_err}, 32'd0);
        check_val("rst_cpu_rdata", cpu_rdata, 32'h0);
        check_val("rst_vga_rvalid", {31'b0, vga_rvalid}, 32'd0);
        check_val("rst_vga_rdata", {24'b0, vga_rdata}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write / read
        cpu_acc(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
        check_val("wr_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        check_val("wr_err", {31'b0, cpu_err}, 32'd0);
        check_val("wr_rdata", cpu_rdata, 32'h0);
        cpu_read_chk("rd1000", 32'h1000, 32'hDEADBEEF);

        // Idle cycle: rvalid drops, rdata holds
        @(negedge clk);
        check_val("idle_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        check_val("idle_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        check_val("idle_err", {31'b0, cpu_err}, 32'd0);

        // VGA byte lanes
        for (int i = 0; i < 4; i++) vga_read_chk($sformatf("vga_lane%0d", i), 32'h1000 + i, lane_exp[i]);

        // Byte enables
        cpu_acc(1'b1, 32'h1000, 4'b0101, 32'h11223344);
        cpu_read_chk("be_rd", 32'h1000, 32'hDE22BE44);

        // Known value in bank 0, then error accesses must not disturb anything
        cpu_acc(1'b1, 32'h0000, 4'hF, 32'h12345678);
        cpu_acc(1'b1, 32'h3000, 4'hF, 32'hFFFFFFFF);
        check_val("oor_wr_err", {31'b0, cpu_err}, 32'd1);
        check_val("oor_wr_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        check_val("oor_wr_rdata", cpu_rdata, 32'h0);
        cpu_acc(1'b1, 32'h1002, 4'hF, 32'hFFFFFFFF);
        check_val("mis_wr_err", {31'b0, cpu_err}, 32'd1);
        cpu_read_chk("after_err_b0", 32'h0000, 32'h12345678);
        cpu_read_chk("after_err_b1", 32'h1000, 32'hDE22BE44);
        cpu_acc(1'b0, 32'h0002, 4'h0, 32'h0);
        check_val("mis_rd_err", {31'b0, cpu_err}, 32'd1);
        check_val("mis_rd_rdata", cpu_rdata, 32'h0);
        vga_read_chk("vga_oor", 32'h3000, 8'h00);

        // Back-to-back write then read of the same word
        @(negedge clk);
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 32'h0004; cpu_be = 4'hF; cpu_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        check_val("b2b_wr_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        cpu_wren = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        check_val("b2b_rd_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        check_val("b2b_rd_rdata", cpu_rdata, 32'hA5A5A5A5);

        // Same-cycle CPU write and VGA read: VGA sees old data
        @(negedge clk);
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 32'h0004; cpu_be = 4'hF; cpu_wdata = 32'h01020304;
        vga_req = 1'b1; vga_addr = 32'h0004;
        @(negedge clk);
        cpu_req = 1'b0; cpu_wren = 1'b0; vga_req = 1'b0;
        check_val("wr_vga_old", {24'b0, vga_rdata}, 32'h000000A5);
        vga_read_chk("vga_new", 32'h0004, 8'h04);

        // Last legal word (bank 2)
        cpu_acc(1'b1, 32'h2FFC, 4'hF, 32'hCAFEF00D);
`ifdef KEY_BANK_EN
        check_val("last_wr_err", {31'b0, cpu_err}, 32'd1);
        // Key bank: key write, then a CPU write must be dropped
        @(negedge clk);
        key_we = 1'b1; key_addr = 10'd0; key_wdata = 32'h00000041;
        @(negedge clk);
        key_we = 1'b0;
        cpu_acc(1'b1, 32'h2000, 4'hF, 32'hFFFFFFFF);
        check_val("key_cpu_wr_err", {31'b0, cpu_err}, 32'd1);
        cpu_read_chk("key_rd", 32'h2000, 32'h00000041);
`else
        check_val("last_wr_err", {31'b0, cpu_err}, 32'd0);
        cpu_read_chk("last_rd", 32'h2FFC, 32'hCAFEF00D);
`endif

        // Reset in the middle of reads; writes during reset are ignored
        @(negedge clk);
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 32'h1000;
        @(posedge clk);
        #2;
        check_val("pre_rst_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        rst_n = 1'b0;
        cpu_wren = 1'b1; cpu_be = 4'hF; cpu_wdata = 32'h0;
        #1;
        check_val("mid_rst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        check_val("mid_rst_rdata", cpu_rdata, 32'h0);
        check_val("mid_rst_err", {31'b0, cpu_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        cpu_req = 1'b0; cpu_wren = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_no_stale", {31'b0, cpu_rvalid}, 32'd0);
        cpu_read_chk("post_rst_mem", 32'h1000, 32'hDE22BE44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
